// File: rtl/division_param.sv
// Sequential restoring divider: unsigned integer dividend / divisor -> fixed-point quotient
// with FRAC_W fractional bits, remainder, optional round-half-up and divide-by-zero flag.
module division_param #(
    parameter int DIVIDEND_W = 10,
    parameter int DIVISOR_W  = 3,
    parameter int FRAC_W     = 10,
    parameter int ROUND      = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [DIVIDEND_W-1:0]            in_data_1_i,
    input  logic [DIVISOR_W-1:0]             in_data_2_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DIVIDEND_W+FRAC_W-1:0]     out_data_o,
    output logic [DIVISOR_W-1:0]             out_rem_o,
    output logic                             out_div0_o
);

    localparam int Q_W   = DIVIDEND_W + FRAC_W;
    localparam int N     = Q_W + ROUND;
    localparam int R_W   = DIVISOR_W + 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         sh_q, sh_d;
    logic [DIVISOR_W-1:0] div_q, div_d;
    logic [R_W-1:0]       r_q, r_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [Q_W-1:0]       data_q, data_d;
    logic [DIVISOR_W-1:0] rem_q, rem_d;
    logic                 div0_q, div0_d;

    logic [R_W:0]         r_shift;
    logic                 qbit;
    logic [R_W-1:0]       r_sel;
    logic [N-1:0]         q_new;
    logic [Q_W-1:0]       q_res;

    // The shift register feeds dividend bits out of its MSB while quotient bits enter at the LSB.
    always_comb begin
        r_shift = {r_q, sh_q[N-1]};
        qbit    = (r_shift >= {2'b00, div_q});
        r_sel   = qbit ? R_W'(r_shift - {2'b00, div_q}) : R_W'(r_shift);
        q_new   = {sh_q[N-2:0], qbit};
    end

    generate
        if (ROUND != 0) begin : g_round
            assign q_res = q_new[N-1:1] + Q_W'(q_new[0]);
        end else begin : g_trunc
            assign q_res = q_new;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        div_d   = div_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    sh_d                      = '0;
                    sh_d[N-1 -: DIVIDEND_W]   = in_data_1_i;
                    div_d                     = in_data_2_i;
                    r_d                       = '0;
                    cnt_d                     = CNT_W'(N - 1);
                    if (in_data_2_i == '0) begin
                        data_d  = '1;
                        rem_d   = '0;
                        div0_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        div0_d  = 1'b0;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                sh_d  = q_new;
                r_d   = r_sel;
                cnt_d = cnt_q - CNT_W'(1);
                // Remainder belongs to the truncated quotient, i.e. before any rounding bit.
                if (cnt_q == CNT_W'(ROUND)) begin
                    rem_d = r_sel[DIVISOR_W-1:0];
                end
                if (cnt_q == '0) begin
                    data_d  = q_res;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            sh_q    <= '0;
            div_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_rem_o   = rem_q;
    assign out_div0_o  = div0_q;

endmodule

// File: tb/tb_division_param.sv
// Bench for division_param: one truncating and one rounding instance, an arithmetic reference
// model checked every valid cycle, plus directed vectors with hand-computed results.
module tb_division_param;

    localparam int FRAC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [9:0]  in_data_1 [2];
    logic [2:0]  in_data_2 [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [19:0] out_data  [2];
    logic [2:0]  out_rem   [2];
    logic        out_div0  [2];

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     pend   [2];
    longint exp_q  [2];
    longint exp_r  [2];
    longint exp_z  [2];
    int     last_acc [2];
    int     last_lat [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    division_param #(.DIVIDEND_W(10), .DIVISOR_W(3), .FRAC_W(10), .ROUND(0)) u_trunc (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_data_1_i(in_data_1[0]), .in_data_2_i(in_data_2[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_data_o(out_data[0]), .out_rem_o(out_rem[0]), .out_div0_o(out_div0[0])
    );

    division_param #(.DIVIDEND_W(10), .DIVISOR_W(3), .FRAC_W(10), .ROUND(1)) u_round (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_data_1_i(in_data_1[1]), .in_data_2_i(in_data_2[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_data_o(out_data[1]), .out_rem_o(out_rem[1]), .out_div0_o(out_div0[1])
    );

    task automatic chk(input string nm, input longint got, input longint expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", nm, got, expv, $time);
        end
    endtask

    // Quotient = floor(a*2^FRAC / b), or floor(a*2^FRAC / b + 1/2) when rounding.
    function automatic longint model_q(input int a, input int b, input int rnd);
        longint num;
        num = longint'(a) << FRAC;
        if (b == 0) return 64'hFFFFF;
        if (rnd != 0) return (2 * num + b) / (2 * b);
        return num / b;
    endfunction

    function automatic longint model_r(input int a, input int b);
        longint num;
        num = longint'(a) << FRAC;
        if (b == 0) return 0;
        return num % b;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (out_valid[i]) begin
                    if (!pend[i]) begin
                        chk($sformatf("unexpected_valid%0d", i), 1, 0);
                    end else begin
                        chk($sformatf("cmp_data%0d", i), out_data[i], exp_q[i]);
                        chk($sformatf("cmp_rem%0d", i), out_rem[i], exp_r[i]);
                        chk($sformatf("cmp_div0_%0d", i), out_div0[i], exp_z[i]);
                    end
                end
            end
        end
    end

    task automatic do_op(input int d, input int a, input int b, input int hold,
                         input longint lit_q, input longint lit_r, input bit b2b);
        int n;
        int acc;
        int nn;
        bit z;
        z  = (b == 0);
        nn = 20 + d;
        n  = 0;
        while (!in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        exp_q[d] = model_q(a, b, d);
        exp_r[d] = model_r(a, b);
        exp_z[d] = z;
        pend[d]  = 1'b1;
        chk("model_q_pin", exp_q[d], lit_q);
        chk("model_r_pin", exp_r[d], lit_r);
        in_data_1[d] = 10'(a);
        in_data_2[d] = 3'(b);
        in_valid[d]  = 1'b1;
        out_ready[d] = (hold == 0);
        @(posedge clk);
        #1;
        acc = cyc;
        if (b2b) chk("b2b_spacing", acc - last_acc[d], last_lat[d] + 2);
        last_acc[d] = acc;
        last_lat[d] = z ? 0 : nn;
        in_valid[d]  = 1'b0;
        in_data_1[d] = ~in_data_1[d];
        in_data_2[d] = in_data_2[d] + 3'd1;
        n = 0;
        @(negedge clk);
        while (!out_valid[d] && n < 60) begin
            @(negedge clk);
            n++;
        end
        // Edges after the accept edge until out_valid is seen: N, or 0 when out_valid is set by the accept edge.
        chk("latency", cyc - acc, z ? 0 : nn);
        if (!out_valid[d]) begin
            pend[d] = 1'b0;
            return;
        end
        chk("out_data", out_data[d], lit_q);
        chk("out_rem", out_rem[d], lit_r);
        chk("out_div0", out_div0[d], z);
        for (int k = 0; k < hold; k++) begin
            chk("bp_valid", out_valid[d], 1);
            chk("bp_in_ready", in_ready[d], 0);
            in_valid[d] = 1'b1;
            @(negedge clk);
        end
        out_ready[d] = 1'b1;
        in_valid[d]  = 1'b0;
        @(negedge clk);
        pend[d] = 1'b0;
        chk("consumed_valid", out_valid[d], 0);
        chk("ready_back", in_ready[d], 1);
        chk("data_held", out_data[d], lit_q);
        chk("div0_held", out_div0[d], z);
        out_ready[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_data_1[i] = '0; in_data_2[i] = '0; out_ready[i] = 1'b0;
            pend[i] = 1'b0; last_acc[i] = 0; last_lat[i] = 0;
            exp_q[i] = 0; exp_r[i] = 0; exp_z[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", out_valid[i], 0);
            chk("rst_data", out_data[i], 0);
            chk("rst_div0", out_div0[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready0", in_ready[0], 1);
        chk("rst_in_ready1", in_ready[1], 1);

        do_op(0, 1000, 3, 0, 341333, 1, 0);
        do_op(0, 1023, 1, 0, 1047552, 0, 1);
        do_op(0, 5, 7, 0, 731, 3, 1);
        do_op(0, 2, 3, 0, 682, 2, 1);
        do_op(0, 1, 3, 0, 341, 1, 1);
        do_op(0, 77, 0, 0, 1048575, 0, 1);
        do_op(0, 5, 7, 5, 731, 3, 0);

        do_op(1, 2, 3, 0, 683, 2, 0);
        do_op(1, 1, 3, 0, 341, 1, 1);
        do_op(1, 1000, 3, 0, 341333, 1, 1);
        do_op(1, 77, 0, 3, 1048575, 0, 0);

        // Abort 1000/3 after its 10th iteration edge.
        in_data_1[0] = 10'd1000;
        in_data_2[0] = 3'd3;
        in_valid[0]  = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mid_in_ready", in_ready[0], 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid[0], 0);
        chk("mid_rst_data", out_data[0], 0);
        chk("mid_rst_rem", out_rem[0], 0);
        chk("mid_rst_div0", out_div0[0], 0);
        chk("mid_rst_in_ready", in_ready[0], 1);
        rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid[0]) bad++;
        end
        chk("no_spurious_valid", bad, 0);
        do_op(0, 6, 2, 0, 3072, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
